sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive data grants allowed while an instruction request waits.
REQ-002 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  in  1  exception flush; cancels delivery of an in-flight instruction response.
REQ-005 SHALL have ports inst_req in 1, inst_addr in 32: fetch request (read only) and word address.
REQ-006 SHALL have ports inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out 32: fetch accept, response strobe, read data.
REQ-007 SHALL have ports data_req in 1, data_wr in 1, data_wstrb in 4, data_addr in 32, data_wdata in 32: load/store request.
REQ-008 SHALL have ports data_addr_ok out 1, data_data_ok out 1, data_rdata out 32: load/store accept, response strobe, read data.
REQ-009 SHALL have ports mem_req out 1, mem_wr out 1, mem_wstrb out 4, mem_addr out 32, mem_wdata out 32: shared memory request.
REQ-010 SHALL have ports mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in 32: shared memory accept, response strobe, read data.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA; at most one transaction outstanding.
REQ-013 In IDLE with any request pending, SHALL pick an owner, latch its wr/wstrb/addr/wdata (inst: wr=0, wstrb=0000, wdata=0) and go to ADDR next cycle; no request: stay IDLE.
REQ-014 Arbitration SHALL grant data over instruction, except that inst wins when inst_req=1 and streak==STARVE_LIMIT.
REQ-015 streak SHALL increment (saturating at STARVE_LIMIT) on each data grant made while inst_req=1, and clear on each inst grant or any data grant made with inst_req=0.
REQ-016 In ADDR, SHALL drive mem_req=1 with latched fields; on mem_addr_ok=1 go to DATA; owner's *_addr_ok = mem_addr_ok combinationally in that cycle; non-owner's addr_ok = 0.
REQ-017 In DATA, mem_req SHALL be 0; on mem_data_ok=1 go to IDLE; owner's *_data_ok = mem_data_ok and *_rdata = mem_rdata in the same cycle.
REQ-018 Minimum transaction SHALL take 3 cycles (IDLE grant, ADDR, DATA) with one IDLE cycle between back-to-back transactions.
REQ-019 Write transactions SHALL still wait for mem_data_ok before leaving DATA; data_rdata is don't-care then but driven from mem_rdata.
REQ-020 flush=1 in any cycle while an inst transaction is in ADDR or DATA SHALL set a cancel flag; the transaction completes on the memory side but inst_data_ok stays 0 for it; the flag clears on return to IDLE.
REQ-021 flush SHALL NOT affect data transactions, and flush in IDLE SHALL have no effect.
REQ-022 *_rdata SHALL be 0 whenever the corresponding *_data_ok is 0.
REQ-023 Requesters SHALL hold req and fields stable until their addr_ok; changes after the IDLE latch cycle SHALL be ignored for the current transaction.
REQ-024 mem_addr_ok/mem_data_ok asserted in a state that does not expect them SHALL be ignored.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, streak 0, cancel flag 0, all latched fields 0, and all outputs 0, including mid-transaction.
REQ-026 After rst release, the first arbitration SHALL occur on the first rising edge with rst=1; any response to a pre-reset transaction SHALL be ignored.

Verification
REQ-027 Single fetch: inst_req=1, addr 0xBFC00000, mem_addr_ok in ADDR, mem_data_ok one cycle later with rdata 0x3C1D0001 -> inst_data_ok=1, inst_rdata=0x3C1D0001, busy low next cycle.
REQ-028 Simultaneous: inst_req and data_req (sw, wstrb 1111, addr 0x80000010, wdata 0xDEADBEEF) same cycle -> data granted first, mem_wr=1, then inst granted.
REQ-029 Starvation: inst_req held high, data_req continuously high, STARVE_LIMIT=4 -> 4 data grants, 5th grant goes to inst, streak cleared.
REQ-030 Flush: inst transaction in DATA, flush pulse, mem_data_ok next cycle -> inst_data_ok stays 0, FSM returns to IDLE, next fetch completes normally.
REQ-031 Reset mid-DATA: rst=0 while waiting for mem_data_ok -> outputs 0 immediately; a stray mem_data_ok after release produces no *_data_ok.
REQ-032 Stalled memory: mem_addr_ok held 0 for 10 cycles -> mem_req stays 1 with stable fields, no addr_ok to requesters until mem_addr_ok=1.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master arbiter sharing one SRAM-like port between instruction fetch and load/store.
// Data wins by default; a bounded streak counter keeps fetches from starving.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  localparam int StreakW = $clog2(STARVE_LIMIT + 2);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arbStateT;

  arbStateT state;
  arbStateT nextState;

  logic               ownerInst;
  logic               latWr;
  logic [3:0]         latWstrb;
  logic [31:0]        latAddr;
  logic [31:0]        latWdata;
  logic [StreakW-1:0] streak;
  logic               cancel;

  logic starved;
  logic grantData;
  logic grantInst;
  logic instDataOk;
  logic dataDataOk;

  // Once the fetch has watched STARVE_LIMIT data grants go by, it takes the next slot.
  assign starved   = inst_req && (streak == StreakMax);
  assign grantData = data_req && !starved;
  assign grantInst = inst_req && !grantData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (grantData || grantInst) nextState = ADDR;
      ADDR: if (mem_addr_ok)            nextState = DATA;
      DATA: if (mem_data_ok)            nextState = IDLE;
      default:                          nextState = IDLE;
    endcase
  end

  // Request fields are captured at grant so later requester changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerInst <= 1'b0;
      latWr     <= 1'b0;
      latWstrb  <= 4'b0000;
      latAddr   <= 32'h0;
      latWdata  <= 32'h0;
      streak    <= '0;
      cancel    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cancel <= 1'b0;
        if (grantData) begin
          ownerInst <= 1'b0;
          latWr     <= data_wr;
          latWstrb  <= data_wstrb;
          latAddr   <= data_addr;
          latWdata  <= data_wdata;
          if (!inst_req) begin
            streak <= '0;
          end else if (streak != StreakMax) begin
            streak <= streak + StreakW'(1);
          end
        end else if (grantInst) begin
          ownerInst <= 1'b1;
          latWr     <= 1'b0;
          latWstrb  <= 4'b0000;
          latAddr   <= inst_addr;
          latWdata  <= 32'h0;
          streak    <= '0;
        end
      end else if (flush && ownerInst) begin
        cancel <= 1'b1;
      end
    end
  end

  // A flush in the completing cycle itself also suppresses the fetch response.
  assign instDataOk = (state == DATA) && ownerInst && mem_data_ok && !cancel && !flush;
  assign dataDataOk = (state == DATA) && !ownerInst && mem_data_ok;

  always_comb begin
    mem_req      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    data_rdata   = 32'h0;
    busy         = (state != IDLE);
    case (state)
      ADDR: begin
        mem_req      = 1'b1;
        inst_addr_ok = ownerInst && mem_addr_ok;
        data_addr_ok = !ownerInst && mem_addr_ok;
      end
      DATA: begin
        inst_data_ok = instDataOk;
        data_data_ok = dataDataOk;
        inst_rdata   = instDataOk ? mem_rdata : 32'h0;
        data_rdata   = dataDataOk ? mem_rdata : 32'h0;
      end
      default: ;
    endcase
  end

  assign mem_wr    = latWr;
  assign mem_wstrb = latWstrb;
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;

endmodule
